// File: rtl/postcode_pkg.sv
// ============================================================================
// Module   : postcode_pkg
// Brief    : Shared state encoding and default timing constants for postcode_link
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package postcode_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam int DEF_LONG_THRESH = 240;    // 5 us at 48 MHz
    localparam int DEF_MIN_PULSE   = 4;
    localparam int DEF_GAP_TIMEOUT = 48000;  // 1 ms at 48 MHz
    localparam int FRAME_PULSES    = 9;

endpackage

`default_nettype wire

// File: rtl/testreq_pulse_meter.sv
// ============================================================================
// Module   : testreq_pulse_meter
// Brief    : Synchronises TESTREQ, detects edges and measures pulse/gap widths
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module testreq_pulse_meter
    import postcode_pkg::*;
#(
    parameter int LONG_THRESH = DEF_LONG_THRESH,
    parameter int MIN_PULSE   = DEF_MIN_PULSE,
    parameter int GAP_TIMEOUT = DEF_GAP_TIMEOUT
) (
    input  logic refclk,
    input  logic reset,
    input  logic testreq,
    output logic rise,
    output logic fall,
    output logic is_long,
    output logic is_glitch,
    output logic gap_timeout
);

    localparam int c_width_bits = $clog2(LONG_THRESH + 1);
    localparam int c_gap_bits   = $clog2(GAP_TIMEOUT + 1);

    localparam logic [c_width_bits-1:0] c_long    = c_width_bits'(LONG_THRESH);
    localparam logic [c_width_bits-1:0] c_min     = c_width_bits'(MIN_PULSE);
    localparam logic [c_width_bits-1:0] c_w_one   = c_width_bits'(1);
    localparam logic [c_gap_bits-1:0]   c_gap_max = c_gap_bits'(GAP_TIMEOUT);
    localparam logic [c_gap_bits-1:0]   c_g_one   = c_gap_bits'(1);

    logic [1:0]              r_sync;
    logic                    r_rq_d;
    logic [c_width_bits-1:0] r_width;
    logic [c_gap_bits-1:0]   r_gap;
    logic                    w_rq;

    assign w_rq        = r_sync[1];
    assign rise        = w_rq & ~r_rq_d;
    assign fall        = ~w_rq & r_rq_d;
    assign is_long     = (r_width >= c_long);
    assign is_glitch   = (r_width < c_min);
    assign gap_timeout = (r_gap == c_gap_max);

    // r_width holds the number of high cycles seen so far, valid on the fall cycle.
    // The gap count survives glitches and restarts only on a qualified fall.
    always_ff @(posedge refclk or posedge reset) begin
        if (reset) begin
            r_sync  <= 2'b00;
            r_rq_d  <= 1'b0;
            r_width <= '0;
            r_gap   <= '0;
        end else begin
            r_sync <= {r_sync[0], testreq};
            r_rq_d <= w_rq;
            if (rise) begin
                r_width <= c_w_one;
            end else if (w_rq && (r_width != c_long)) begin
                r_width <= r_width + c_w_one;
            end
            if (fall && !is_glitch) begin
                r_gap <= c_g_one;
            end else if (r_gap != c_gap_max) begin
                r_gap <= r_gap + c_g_one;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/postcode_link.sv
// ============================================================================
// Module   : postcode_link
// Brief    : TESTREQ/TESTACK pulse-width frame engine with one-byte rx/tx buffers
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module postcode_link
    import postcode_pkg::*;
#(
    parameter int LONG_THRESH = DEF_LONG_THRESH,
    parameter int MIN_PULSE   = DEF_MIN_PULSE,
    parameter int GAP_TIMEOUT = DEF_GAP_TIMEOUT
) (
    input  logic       refclk,
    input  logic       reset,
    input  logic       testreq,
    output logic       testack,
    output logic [7:0] rxout,
    output logic       rxfull,
    input  logic       rxreset,
    output logic       rxoverrun,
    input  logic [7:0] txin,
    input  logic       txstart,
    output logic       txempty
);

    localparam logic [3:0] c_last_bit = 4'(FRAME_PULSES - 1);

    state_t     r_state;
    state_t     w_state_next;
    logic [3:0] r_bitcnt;
    logic       r_box_flag;
    logic       r_tgt_flag;
    logic [7:0] r_tx_buf;
    logic [7:0] r_tx_shift;
    logic [7:0] r_rx_shift;
    logic [7:0] r_rxout;
    logic       r_txempty;
    logic       r_rxfull;
    logic       r_rxoverrun;
    logic       r_testack;

    logic       w_rise;
    logic       w_fall;
    logic       w_is_long;
    logic       w_is_glitch;
    logic       w_gap_timeout;
    logic       w_qual_fall;
    logic       w_complete;
    logic       w_cur_bit;
    logic [7:0] w_rx_byte;

    testreq_pulse_meter #(
        .LONG_THRESH (LONG_THRESH),
        .MIN_PULSE   (MIN_PULSE),
        .GAP_TIMEOUT (GAP_TIMEOUT)
    ) u_meter (
        .refclk      (refclk),
        .reset       (reset),
        .testreq     (testreq),
        .rise        (w_rise),
        .fall        (w_fall),
        .is_long     (w_is_long),
        .is_glitch   (w_is_glitch),
        .gap_timeout (w_gap_timeout)
    );

    assign w_qual_fall = (r_state == ST_PULSE) && w_fall && !w_is_glitch;
    assign w_complete  = w_qual_fall && (r_bitcnt == c_last_bit);
    assign w_rx_byte   = {r_rx_shift[6:0], w_is_long};

    assign testack   = r_testack;
    assign rxout     = r_rxout;
    assign rxfull    = r_rxfull;
    assign rxoverrun = r_rxoverrun;
    assign txempty   = r_txempty;

    always_ff @(posedge refclk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A glitch returns to IDLE only if no pulse of this frame has qualified yet.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_rise) w_state_next = ST_PULSE;
            end
            ST_PULSE: begin
                if (w_fall) begin
                    if (w_is_glitch) begin
                        w_state_next = (r_bitcnt == 4'd0) ? ST_IDLE : ST_GAP;
                    end else if (r_bitcnt == c_last_bit) begin
                        w_state_next = ST_IDLE;
                    end else begin
                        w_state_next = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (w_rise) begin
                    w_state_next = ST_PULSE;
                end else if (w_gap_timeout) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // In IDLE the flag about to be latched is shown directly, so TESTACK is valid on the rise.
    always_comb begin
        w_cur_bit = 1'b0;
        if (r_state == ST_IDLE) begin
            w_cur_bit = !r_txempty;
        end else if (r_bitcnt == 4'd0) begin
            w_cur_bit = r_box_flag;
        end else begin
            w_cur_bit = r_box_flag && r_tx_shift[7];
        end
    end

    always_ff @(posedge refclk or posedge reset) begin
        if (reset) begin
            r_bitcnt    <= 4'd0;
            r_box_flag  <= 1'b0;
            r_tgt_flag  <= 1'b0;
            r_tx_buf    <= 8'h00;
            r_tx_shift  <= 8'h00;
            r_rx_shift  <= 8'h00;
            r_rxout     <= 8'h00;
            r_txempty   <= 1'b1;
            r_rxfull    <= 1'b0;
            r_rxoverrun <= 1'b0;
            r_testack   <= 1'b0;
        end else begin
            r_rxoverrun <= 1'b0;
            r_testack   <= (w_state_next == ST_PULSE) && w_cur_bit;

            if ((r_state == ST_IDLE) && w_rise) begin
                r_box_flag <= !r_txempty;
                r_tx_shift <= r_tx_buf;
            end

            if (w_qual_fall) begin
                if (r_bitcnt == 4'd0) begin
                    r_tgt_flag <= w_is_long;
                end else begin
                    r_rx_shift <= w_rx_byte;
                    r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                end
            end

            if (w_state_next == ST_IDLE) begin
                r_bitcnt <= 4'd0;
            end else if (w_qual_fall) begin
                r_bitcnt <= r_bitcnt + 4'd1;
            end

            if (rxreset) begin
                r_rxfull <= 1'b0;
            end
            if (txstart && r_txempty) begin
                r_tx_buf  <= txin;
                r_txempty <= 1'b0;
            end

            if (w_complete) begin
                if (r_box_flag) begin
                    r_txempty <= 1'b1;
                end
                if (r_tgt_flag) begin
                    if (!r_rxfull || rxreset) begin
                        r_rxout  <= w_rx_byte;
                        r_rxfull <= 1'b1;
                    end else begin
                        r_rxoverrun <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_postcode_link.sv
// ============================================================================
// Module   : tb_postcode_link
// Brief    : Randomised frame-level bench for postcode_link with buffer model
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_postcode_link;

    localparam int LT = 32;
    localparam int MP = 4;
    localparam int GT = 600;

    logic       refclk = 1'b0;
    logic       reset;
    logic       testreq;
    logic       testack;
    logic [7:0] rxout;
    logic       rxfull;
    logic       rxreset;
    logic       rxoverrun;
    logic [7:0] txin;
    logic       txstart;
    logic       txempty;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: buffer contents as seen from the bridge side
    logic       m_txempty;
    logic [7:0] m_txbyte;
    logic       m_rxfull;
    logic [7:0] m_rxout;

    always #5 refclk = ~refclk;

    postcode_link #(
        .LONG_THRESH (LT),
        .MIN_PULSE   (MP),
        .GAP_TIMEOUT (GT)
    ) dut (
        .refclk    (refclk),
        .reset     (reset),
        .testreq   (testreq),
        .testack   (testack),
        .rxout     (rxout),
        .rxfull    (rxfull),
        .rxreset   (rxreset),
        .rxoverrun (rxoverrun),
        .txin      (txin),
        .txstart   (txstart),
        .txempty   (txempty)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge refclk);
        #1;
    endtask

    function automatic int pick_width(input logic b);
        int r;
        r = $urandom_range(3, 0);
        if (b) return (r == 0) ? LT : $urandom_range(LT + 15, LT);
        if (r == 0) return LT - 1;
        if (r == 1) return MP;
        return $urandom_range(LT - 1, MP);
    endfunction

    task automatic pulse(input int w, input logic exp_ack);
        testreq = 1'b1;
        tick(w);
        chk("pulse_ack", {31'd0, testack}, {31'd0, exp_ack});
        testreq = 1'b0;
    endtask

    task automatic gap(input bit glitch);
        if (glitch) begin
            tick($urandom_range(12, 4));
            testreq = 1'b1;
            tick($urandom_range(MP - 1, 1));
            testreq = 1'b0;
            tick($urandom_range(12, 4));
        end else begin
            tick($urandom_range(40, 4));
        end
        chk("gap_ack", {31'd0, testack}, 32'd0);
    endtask

    task automatic send_tx(input logic [7:0] b);
        txin    = b;
        txstart = 1'b1;
        tick(1);
        txstart = 1'b0;
        if (m_txempty) begin
            m_txbyte  = b;
            m_txempty = 1'b0;
        end
        chk("txempty_load", {31'd0, txempty}, {31'd0, m_txempty});
    endtask

    task automatic send_rxreset();
        rxreset = 1'b1;
        tick(1);
        rxreset = 1'b0;
        m_rxfull = 1'b0;
        chk("rxfull_clear", {31'd0, rxfull}, 32'd0);
    endtask

    task automatic run_frame(input logic tflag, input logic [7:0] tbyte, input bit rxr_done,
                             input bit mid_tx, input int glitch_pct);
        logic       box;
        logic [7:0] bbyte;
        logic [8:0] tbits;
        logic       exp_ovr;
        box   = ~m_txempty;
        bbyte = m_txbyte;
        tbits = {tflag, tbyte};
        for (int k = 0; k < 9; k++) begin
            pulse(pick_width(tbits[8-k]), (k == 0) ? box : (box & bbyte[8-k]));
            if (k < 8) begin
                gap($urandom_range(99, 0) < glitch_pct);
                if (mid_tx && k == 3) send_tx(8'($urandom));
            end
        end
        tick(2);
        chk("early_txempty", {31'd0, txempty}, {31'd0, m_txempty});
        rxreset = rxr_done;
        tick(1);
        rxreset = 1'b0;
        exp_ovr = 1'b0;
        if (box) m_txempty = 1'b1;
        if (tflag) begin
            if (!m_rxfull || rxr_done) begin
                m_rxout  = tbyte;
                m_rxfull = 1'b1;
            end else begin
                exp_ovr = 1'b1;
            end
        end else if (rxr_done) begin
            m_rxfull = 1'b0;
        end
        chk("rxfull",    {31'd0, rxfull},    {31'd0, m_rxfull});
        chk("rxout",     {24'd0, rxout},     {24'd0, m_rxout});
        chk("txempty",   {31'd0, txempty},   {31'd0, m_txempty});
        chk("rxoverrun", {31'd0, rxoverrun}, {31'd0, exp_ovr});
        tick(1);
        chk("ovr_one_cycle", {31'd0, rxoverrun}, 32'd0);
    endtask

    task automatic abort_frame(input int n);
        logic       box;
        logic [7:0] bbyte;
        box   = ~m_txempty;
        bbyte = m_txbyte;
        for (int k = 0; k < n; k++) begin
            pulse(pick_width((k == 0) ? 1'b1 : 1'($urandom_range(1, 0))),
                  (k == 0) ? box : (box & bbyte[8-k]));
            if (k < n - 1) gap(1'b0);
        end
        tick(GT + 40);
        chk("abort_rxfull",  {31'd0, rxfull},    {31'd0, m_rxfull});
        chk("abort_txempty", {31'd0, txempty},   {31'd0, m_txempty});
        chk("abort_ack",     {31'd0, testack},   32'd0);
        chk("abort_ovr",     {31'd0, rxoverrun}, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        reset   = 1'b1;
        testreq = 1'b0;
        rxreset = 1'b0;
        txstart = 1'b0;
        txin    = 8'h00;
        m_txempty = 1'b1;
        m_txbyte  = 8'h00;
        m_rxfull  = 1'b0;
        m_rxout   = 8'h00;
        tick(3);
        chk("rst_testack",   {31'd0, testack},   32'd0);
        chk("rst_rxout",     {24'd0, rxout},     32'd0);
        chk("rst_rxfull",    {31'd0, rxfull},    32'd0);
        chk("rst_txempty",   {31'd0, txempty},   32'd1);
        chk("rst_rxoverrun", {31'd0, rxoverrun}, 32'd0);
        reset = 1'b0;
        tick(3);

        run_frame(1'b1, 8'hA5, 1'b0, 1'b0, 0);   // target-to-box only
        send_tx(8'h3C);
        run_frame(1'b0, 8'h00, 1'b0, 1'b0, 0);   // box-to-target only
        send_rxreset();
        send_tx(8'h7E);
        run_frame(1'b1, 8'h81, 1'b0, 1'b0, 0);   // full duplex
        run_frame(1'b1, 8'h11, 1'b0, 1'b0, 0);   // overrun
        run_frame(1'b1, 8'h11, 1'b1, 1'b0, 0);   // rxreset on completion wins
        send_tx(8'hC3);
        send_tx(8'h99);                          // ignored while full
        abort_frame(4);
        run_frame(1'b1, 8'h22, 1'b1, 1'b0, 0);   // resends 8'hC3
        run_frame(1'b1, 8'h5E, 1'b1, 1'b1, 100); // glitches, mid-frame load not sent
        run_frame(1'b0, 8'h00, 1'b0, 1'b0, 0);   // now sends the mid-frame byte

        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(1, 0) == 1) send_tx(8'($urandom));
            if ($urandom_range(3, 0) == 0) send_rxreset();
            run_frame(1'($urandom_range(1, 0)), 8'($urandom),
                      ($urandom_range(3, 0) == 0), ($urandom_range(3, 0) == 0), 20);
            tick(4);
        end

        // Reset in the middle of pulse 5 with both buffers occupied
        if (!m_txempty) run_frame(1'b0, 8'h00, 1'b0, 1'b0, 0);
        run_frame(1'b1, 8'h5A, 1'b1, 1'b0, 0);
        send_tx(8'hFF);
        for (int k = 0; k < 5; k++) begin
            pulse(pick_width(1'($urandom_range(1, 0))), 1'b1);
            gap(1'b0);
        end
        testreq = 1'b1;
        tick(6);
        chk("pre_reset_ack", {31'd0, testack}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("midrst_ack",     {31'd0, testack}, 32'd0);
        chk("midrst_txempty", {31'd0, txempty}, 32'd1);
        chk("midrst_rxfull",  {31'd0, rxfull},  32'd0);
        chk("midrst_rxout",   {24'd0, rxout},   32'd0);
        testreq = 1'b0;
        tick(2);
        reset = 1'b0;
        m_txempty = 1'b1;
        m_rxfull  = 1'b0;
        m_rxout   = 8'h00;
        tick(3);
        send_tx(8'h96);
        run_frame(1'b1, 8'h69, 1'b0, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
